regfile_param: RTL
==================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register and bus width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5: address width; depth is 2**ADDR_W registers.
REQ-003 SHALL have parameter NREAD, default 2: number of read ports, legal range 1..4.
REQ-004 SHALL have parameter BYPASS, default 1: 1 forwards same-cycle write data to reads; 0 returns stored data.
REQ-005 SHALL have port Clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-006 SHALL have port Reset, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port WEN, input, 1 bit: write enable.
REQ-008 SHALL have port RW, input, ADDR_W bits: write address.
REQ-009 SHALL have port busW, input, DATA_W bits: write data.
REQ-010 SHALL have port RX, input, NREAD*ADDR_W bits: read addresses; port i is at bits [i*ADDR_W +: ADDR_W].
REQ-011 SHALL have port busX, output, NREAD*DATA_W bits: read data; port i is at bits [i*DATA_W +: DATA_W].
REQ-012 SHALL have port IssueEn, input, 1 bit: marks the destination of an issued instruction as pending.
REQ-013 SHALL have port IssueRd, input, ADDR_W bits: destination register being issued.
REQ-014 SHALL have port Flush, input, 1 bit: clears all pending marks.
REQ-015 SHALL have port Busy, output, NREAD bits: pending status of the register addressed by each read port.
REQ-016 SHALL have port PendCnt, output, ADDR_W bits: number of registers currently pending.

Function
REQ-017 SHALL write busW into register RW at the rising Clk edge when WEN=1 and RW!=0; a write with RW=0 has no effect.
REQ-018 SHALL keep register 0 reading as zero at all times.
REQ-019 SHALL make reads combinational (zero latency): busX port i = 0 when RX_i=0; else busW when BYPASS=1, WEN=1 and RW=RX_i; else stored register RX_i.
REQ-020 SHALL keep one pending bit per register; the pending bit for register 0 is hardwired 0.
REQ-021 SHALL set pending[IssueRd] at the clock edge when IssueEn=1 and IssueRd!=0.
REQ-022 SHALL clear pending[RW] at the clock edge when WEN=1 and RW!=0.
REQ-023 SHALL, when a set and a clear target the same register in the same cycle, leave that register pending (set wins).
REQ-024 SHALL apply Flush=1 at the clock edge by clearing every pending bit, overriding any set or clear in that cycle; register data is unaffected.
REQ-025 SHALL drive Busy_i = pending[RX_i] AND NOT (BYPASS AND WEN AND RW=RX_i AND RW!=0).
REQ-026 SHALL make PendCnt a registered population count of the pending bits, updated at the same edge as those bits; maximum value is 2**ADDR_W-1.
REQ-027 SHALL resolve multiple read ports addressing the same register independently, each receiving identical data.

Reset
REQ-028 SHALL, while Reset=0 and regardless of Clk, clear all registers, all pending bits and PendCnt to 0; busX=0 and Busy=0 follow combinationally.
REQ-029 SHALL ignore all write, issue and flush activity while Reset=0; the first update happens at the first rising edge after Reset rises.

Structure
REQ-030 SHALL place default parameter values and the zero-register constant in shared package regfile_pkg.
REQ-031 SHALL implement the pending bits, set/clear/flush logic and PendCnt in sub-module rf_scoreboard; storage and read muxing stay in the top module.

Verification
REQ-032 SHALL cover write/read: WEN=1, RW=5, busW=0xDEADBEEF, then the next cycle RX0=5 -> busX0=0xDEADBEEF.
REQ-033 SHALL cover register 0 protection: WEN=1, RW=0, busW=0xFFFFFFFF, then RX0=0 -> busX0=0, and a same-cycle read -> 0.
REQ-034 SHALL cover the bypass path: reg 7 holds 0x11; in the same cycle WEN=1, RW=7, busW=0x22, RX1=7 -> busX1=0x22 with BYPASS=1 and 0x11 with BYPASS=0.
REQ-035 SHALL cover the scoreboard: IssueEn, IssueRd=3 -> next cycle RX0=3 gives Busy0=1 and PendCnt=1; then WEN, RW=3 -> Busy0=0 and PendCnt=0.
REQ-036 SHALL cover simultaneous set and clear plus Flush: IssueRd=4 with WEN, RW=4 in the same cycle -> pending[4]=1; then Flush=1 with IssueEn, IssueRd=9 -> PendCnt=0.
REQ-037 SHALL cover mid-operation reset: with regs 1..31 written and 3 pending, assert Reset=0 between edges -> all busX=0, Busy=0 and PendCnt=0 immediately.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults for the parameterised register file and its scoreboard.
package regfile_pkg;
  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;
  localparam int DEFAULT_NREAD  = 2;
  localparam int DEFAULT_BYPASS = 1;
  localparam int ZERO_REG       = 0;
endpackage

// File: rtl/regfile_param_if.sv
// Link between the register file and its pending-bit scoreboard.
interface regfile_param_if
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);
  logic                   wen;
  logic [ADDR_W-1:0]      rw;
  logic                   issue_en;
  logic [ADDR_W-1:0]      issue_rd;
  logic                   flush;
  logic [2**ADDR_W-1:0]   pending;
  logic [ADDR_W-1:0]      pend_cnt;

  modport master (output wen, rw, issue_en, issue_rd, flush, input pending, pend_cnt);
  modport slave  (input wen, rw, issue_en, issue_rd, flush, output pending, pend_cnt);
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending bits (issue sets, write-back clears, flush wipes) and their count.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input logic             Clk,
  input logic             Reset,
  regfile_param_if.slave  sb
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0]  r_pending;
  logic [DEPTH-1:0]  w_pending_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;

  // NOTE: every always_comb output is given a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_pending_nxt = r_pending;
    if (sb.wen)
      w_pending_nxt[sb.rw] = 1'b0;
    // Set is applied after clear so an issue to the register being written back wins.
    if (sb.issue_en)
      w_pending_nxt[sb.issue_rd] = 1'b1;
    if (sb.flush)
      w_pending_nxt = '0;
    w_pending_nxt[ZERO_REG] = 1'b0;

    w_cnt_nxt = '0;
    for (int i = 1; i < DEPTH; i++)
      w_cnt_nxt = w_cnt_nxt + ADDR_W'(w_pending_nxt[i]);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_pending <= '0;
      r_cnt     <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign sb.pending  = r_pending;
  assign sb.pend_cnt = r_cnt;
endmodule

// File: rtl/regfile_param.sv
// Multi-port register file with zero register, optional write bypass and issue scoreboard.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NREAD  = DEFAULT_NREAD,
  parameter int BYPASS = DEFAULT_BYPASS
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     WEN,
  input  logic [ADDR_W-1:0]        RW,
  input  logic [DATA_W-1:0]        busW,
  input  logic [NREAD*ADDR_W-1:0]  RX,
  output logic [NREAD*DATA_W-1:0]  busX,
  input  logic                     IssueEn,
  input  logic [ADDR_W-1:0]        IssueRd,
  input  logic                     Flush,
  output logic [NREAD-1:0]         Busy,
  output logic [ADDR_W-1:0]        PendCnt
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic              w_wr_valid;

  assign w_wr_valid = WEN && (RW != ADDR_W'(ZERO_REG));

  // NOTE: the storage array is reset because the register file must read all-zero straight out of reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++)
        r_regs[i] <= '0;
    end else if (w_wr_valid) begin
      r_regs[RW] <= busW;
    end
  end

  regfile_param_if #(.ADDR_W(ADDR_W)) sb_if ();

  assign sb_if.wen      = w_wr_valid;
  assign sb_if.rw       = RW;
  assign sb_if.issue_en = IssueEn && (IssueRd != ADDR_W'(ZERO_REG));
  assign sb_if.issue_rd = IssueRd;
  assign sb_if.flush    = Flush;
  assign PendCnt        = sb_if.pend_cnt;

  rf_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .Clk   (Clk),
    .Reset (Reset),
    .sb    (sb_if.slave)
  );

  // Bypass is gated by Reset so writes in flight during reset never leak to the read ports.
  for (genvar g = 0; g < NREAD; g++) begin : g_read
    logic [ADDR_W-1:0] w_ra;
    logic              w_hit;

    assign w_ra  = RX[g*ADDR_W +: ADDR_W];
    assign w_hit = (BYPASS != 0) && Reset && w_wr_valid && (RW == w_ra);
    assign busX[g*DATA_W +: DATA_W] = (w_ra == ADDR_W'(ZERO_REG)) ? '0 :
                                      w_hit ? busW : r_regs[w_ra];
    assign Busy[g] = sb_if.pending[w_ra] && !w_hit;
  end
endmodule
